rf_gen_cfg_ctrl: RTL and testbench

Configuration sequencer for the 6-channel RF clock generator (divider plus phase-delay per channel).
- Holds host-writable shadow registers for every channel's div and phase_delay.
- On commit, applies all channels at once: copies shadow to live outputs and holds the generator in reset for a fixed window, so every channel restarts phase-aligned with its new phase offset.
- Sits between the host register bus and the generator's div*/phase_delay*/reset inputs.

---
 rtl/rf_gen_pkg.sv | 22 ++
 rtl/rf_gen_ch_cfg.sv | 67 ++++++
 rtl/rf_gen_cfg_ctrl.sv | 142 ++++++++++++++
 tb/tb_rf_gen_cfg_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_gen_pkg.sv
// Shared definitions for the RF clock generator configuration sequencer.
package rf_gen_pkg;

  localparam int NUM_CH = 6;
  localparam int DW     = 8;

  // cfg_addr layout: bit 3 selects div/phase, bits 2:0 select the channel
  localparam int ADDR_SEL_BIT = 3;
  localparam int CH_MSB       = 2;
  localparam int CH_LSB       = 0;

  localparam logic [DW-1:0] DEF_DIV = 8'd4;
  localparam logic [DW-1:0] MIN_DIV = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_APPLY,
    ST_HOLD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/rf_gen_ch_cfg.sv
// One generator channel: shadow and live div/phase registers, the div
// write clamp, the simultaneous live load and the div+phase overflow flag.
module rf_gen_ch_cfg #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] DEF_DIV = 8'd4,
  parameter logic [DW-1:0] MIN_DIV = 8'd1
) (
  input  logic          refclk,
  input  logic          reset,
  input  logic          wr_div,
  input  logic          wr_phase,
  input  logic [DW-1:0] wr_data,
  input  logic          load,
  output logic [DW-1:0] div_live,
  output logic [DW-1:0] phase_live,
  output logic          ovf
);

  logic [DW-1:0] div_sh_q, div_sh_d;
  logic [DW-1:0] phase_sh_q, phase_sh_d;
  logic [DW-1:0] div_live_q, div_live_d;
  logic [DW-1:0] phase_live_q, phase_live_d;
  logic [DW:0]   sum;

  // Next-state for shadow (host writes, div clamped) and live (load on apply)
  always_comb begin
    div_sh_d     = div_sh_q;
    phase_sh_d   = phase_sh_q;
    div_live_d   = div_live_q;
    phase_live_d = phase_live_q;
    if (wr_div) begin
      div_sh_d = (wr_data < MIN_DIV) ? MIN_DIV : wr_data;
    end
    if (wr_phase) begin
      phase_sh_d = wr_data;
    end
    if (load) begin
      div_live_d   = div_sh_q;
      phase_live_d = phase_sh_q;
    end
  end

  // Register all four values; reset returns everything to defaults
  always_ff @(posedge refclk) begin
    if (reset) begin
      div_sh_q     <= DEF_DIV;
      phase_sh_q   <= '0;
      div_live_q   <= DEF_DIV;
      phase_live_q <= '0;
    end else begin
      div_sh_q     <= div_sh_d;
      phase_sh_q   <= phase_sh_d;
      div_live_q   <= div_live_d;
      phase_live_q <= phase_live_d;
    end
  end

  // Overflow when the one-bit-wider sum of shadow div and phase carries out
  always_comb begin
    sum = {1'b0, div_sh_q} + {1'b0, phase_sh_q};
    ovf = sum[DW];
  end

  assign div_live   = div_live_q;
  assign phase_live = phase_live_q;

endmodule

// File: rtl/rf_gen_cfg_ctrl.sv
// Configuration sequencer for the 6-channel RF clock generator. Host writes
// land in per-channel shadows; a commit copies all shadows to the live
// outputs at once and holds the generator in reset so channels restart aligned.
module rf_gen_cfg_ctrl #(
  parameter int            NUM_CH     = 6,
  parameter int            DW         = 8,
  parameter int            RST_CYCLES = 4,
  parameter logic [DW-1:0] DEF_DIV    = rf_gen_pkg::DEF_DIV,
  parameter logic [DW-1:0] MIN_DIV    = rf_gen_pkg::MIN_DIV
) (
  input  logic               refclk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [3:0]         cfg_addr,
  input  logic [DW-1:0]      cfg_data,
  input  logic               commit,
  input  logic               err_clr,
  output logic [NUM_CH*DW-1:0] div_out,
  output logic [NUM_CH*DW-1:0] phase_out,
  output logic               gen_reset,
  output logic               busy,
  output logic               done,
  output logic               commit_drop,
  output logic [1:0]         err
);

  import rf_gen_pkg::*;

  localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [1:0]        err_q, err_d;
  logic [2:0]        wr_ch;
  logic              wr_is_phase;
  logic              wr_en;
  logic              ch_valid;
  logic [NUM_CH-1:0] wr_div_vec;
  logic [NUM_CH-1:0] wr_phase_vec;
  logic [NUM_CH-1:0] ovf_vec;
  logic              apply_now;

  assign wr_ch       = cfg_addr[CH_MSB:CH_LSB];
  assign wr_is_phase = cfg_addr[ADDR_SEL_BIT];
  assign wr_en       = cfg_valid && cfg_ready;
  assign ch_valid    = (wr_ch < 3'(NUM_CH));
  assign apply_now   = (state_q == ST_APPLY);

  // Sequence IDLE -> APPLY (1) -> HOLD (RST_CYCLES) -> DONE (1) -> IDLE
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
      ST_HOLD: begin
        if (hold_cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          state_d = ST_DONE;
        end else begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and hold counter registers
  always_ff @(posedge refclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Sticky errors: clear first so a same-cycle set takes priority
  always_comb begin
    err_d = err_q;
    if (err_clr) begin
      err_d = 2'b00;
    end
    if (wr_en && !ch_valid) begin
      err_d[0] = 1'b1;
    end
    if (apply_now && (|ovf_vec)) begin
      err_d[1] = 1'b1;
    end
  end

  // Error register
  always_ff @(posedge refclk) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign wr_div_vec[g]   = wr_en && !wr_is_phase && (wr_ch == 3'(g));
    assign wr_phase_vec[g] = wr_en &&  wr_is_phase && (wr_ch == 3'(g));

    rf_gen_ch_cfg #(
      .DW      (DW),
      .DEF_DIV (DEF_DIV),
      .MIN_DIV (MIN_DIV)
    ) u_ch (
      .refclk     (refclk),
      .reset      (reset),
      .wr_div     (wr_div_vec[g]),
      .wr_phase   (wr_phase_vec[g]),
      .wr_data    (cfg_data),
      .load       (apply_now),
      .div_live   (div_out[g*DW +: DW]),
      .phase_live (phase_out[g*DW +: DW]),
      .ovf        (ovf_vec[g])
    );
  end

  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE) && !reset;
  assign commit_drop = commit && busy && !reset;
  assign gen_reset   = reset | (state_q == ST_HOLD);
  assign err         = err_q;

endmodule

// File: tb/tb_rf_gen_cfg_ctrl.sv
// Randomized scoreboard bench for rf_gen_cfg_ctrl with a behavioural model.
module tb_rf_gen_cfg_ctrl;

  localparam int NUM_CH     = 6;
  localparam int DW         = 8;
  localparam int RST_CYCLES = 4;

  logic                 refclk = 1'b0;
  logic                 reset = 1'b1;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [3:0]           cfg_addr = '0;
  logic [DW-1:0]        cfg_data = '0;
  logic                 commit = 1'b0;
  logic                 err_clr = 1'b0;
  logic [NUM_CH*DW-1:0] div_out;
  logic [NUM_CH*DW-1:0] phase_out;
  logic                 gen_reset;
  logic                 busy;
  logic                 done;
  logic                 commit_drop;
  logic [1:0]           err;

  rf_gen_cfg_ctrl #(
    .NUM_CH     (NUM_CH),
    .DW         (DW),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .refclk      (refclk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .commit      (commit),
    .err_clr     (err_clr),
    .div_out     (div_out),
    .phase_out   (phase_out),
    .gen_reset   (gen_reset),
    .busy        (busy),
    .done        (done),
    .commit_drop (commit_drop),
    .err         (err)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [NUM_CH*DW-1:0] div;
    logic [NUM_CH*DW-1:0] phase;
    logic [1:0]           err;
  } exp_t;

  exp_t exp_q[$];

  int   m_div[NUM_CH];
  int   m_phase[NUM_CH];
  int   m_ldiv[NUM_CH];
  int   m_lphase[NUM_CH];
  logic [1:0] m_err;

  int checks = 0;
  int failures = 0;
  int hold_run = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_div[i] = 4; m_phase[i] = 0; m_ldiv[i] = 4; m_lphase[i] = 0;
    end
    m_err = 2'b00;
  endfunction

  function automatic void modelWrite(input logic [3:0] a, input logic [7:0] d);
    int ch;
    ch = int'(a[2:0]);
    if (ch >= NUM_CH) m_err[0] = 1'b1;
    else if (a[3]) m_phase[ch] = int'(d);
    else m_div[ch] = (int'(d) < 1) ? 1 : int'(d);
  endfunction

  function automatic logic [NUM_CH*DW-1:0] packArr(input int v[NUM_CH]);
    logic [NUM_CH*DW-1:0] r;
    logic [31:0] t;
    r = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      t = v[i];
      r[i*DW +: DW] = t[7:0];
    end
    return r;
  endfunction

  // Scoreboard monitor: one expected entry per completed apply, and HOLD length
  always @(negedge refclk) begin
    exp_t e;
    if (reset !== 1'b0) begin
      hold_run = 0;
    end else begin
      if (gen_reset === 1'b1) hold_run++;
      else begin
        if (hold_run > 0) checkOutput("hold_len", 64'(hold_run), 64'(RST_CYCLES));
        hold_run = 0;
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0) checkOutput("unexpected_done", 64'(done), 64'd0);
        else begin
          e = exp_q.pop_front();
          checkOutput("sb_div", 64'(div_out), 64'(e.div));
          checkOutput("sb_phase", 64'(phase_out), 64'(e.phase));
          checkOutput("sb_err", 64'(err), 64'(e.err));
        end
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 100) begin
      @(negedge refclk);
      n++;
    end
    if (n >= 100) checkOutput("idle_timeout", 64'(cfg_ready), 64'd1);
  endtask

  // Host write in IDLE; live outputs must not move
  task automatic applyStimulus(input logic [3:0] a, input logic [7:0] d);
    waitIdle();
    @(negedge refclk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge refclk);
    modelWrite(a, d);
    @(negedge refclk);
    cfg_valid = 1'b0;
    checkOutput("wr_live_div", 64'(div_out), 64'(packArr(m_ldiv)));
    checkOutput("wr_live_phase", 64'(phase_out), 64'(packArr(m_lphase)));
    checkOutput("wr_err", 64'(err), 64'(m_err));
  endtask

  task automatic errClear(input bit with_bad);
    waitIdle();
    @(negedge refclk);
    err_clr = 1'b1;
    if (with_bad) begin cfg_valid = 1'b1; cfg_addr = 4'b0111; cfg_data = 8'h5A; end
    @(posedge refclk);
    m_err = 2'b00;
    if (with_bad) m_err[0] = 1'b1;
    @(negedge refclk);
    err_clr = 1'b0; cfg_valid = 1'b0;
    checkOutput("err_clr", 64'(err), 64'(m_err));
  endtask

  task automatic doCommit(input bit probe, input bit same_wr, input logic [3:0] sw_a,
                          input logic [7:0] sw_d, input bit rst_mid);
    exp_t e;
    logic [NUM_CH*DW-1:0] old_div, old_phase;
    logic [3:0] pa;
    logic [7:0] pd;
    bit ovf;
    pa = 4'($urandom_range(0, 13)); pd = 8'($urandom_range(0, 255));
    if (pa[2:0] > 3'd5) pa[2:0] = 3'd3;
    waitIdle();
    @(negedge refclk);
    old_div = packArr(m_ldiv); old_phase = packArr(m_lphase);
    commit = 1'b1;
    if (same_wr) begin cfg_valid = 1'b1; cfg_addr = sw_a; cfg_data = sw_d; end
    @(posedge refclk);
    if (same_wr) modelWrite(sw_a, sw_d);
    ovf = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_div[i] + m_phase[i] > 255) ovf = 1'b1;
      m_ldiv[i] = m_div[i]; m_lphase[i] = m_phase[i];
    end
    if (ovf) m_err[1] = 1'b1;
    e.div = packArr(m_ldiv); e.phase = packArr(m_lphase); e.err = m_err;
    exp_q.push_back(e);
    for (int k = 1; k <= 3 + RST_CYCLES; k++) begin
      @(negedge refclk);
      if (k == 1) begin commit = 1'b0; cfg_valid = 1'b0; end
      checkOutput("t_div", 64'(div_out), 64'((k >= 2) ? e.div : old_div));
      checkOutput("t_phase", 64'(phase_out), 64'((k >= 2) ? e.phase : old_phase));
      checkOutput("t_gen_reset", 64'(gen_reset), 64'(k >= 2 && k <= 1 + RST_CYCLES));
      checkOutput("t_done", 64'(done), 64'(k == 2 + RST_CYCLES));
      checkOutput("t_ready", 64'(cfg_ready), 64'(k == 3 + RST_CYCLES));
      checkOutput("t_busy", 64'(busy), 64'(k <= 2 + RST_CYCLES));
      if (rst_mid && k == 3) begin
        reset = 1'b1;
        exp_q.delete();
        @(negedge refclk);
        checkOutput("rst_gen_reset", 64'(gen_reset), 64'd1);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        modelReset();
        @(negedge refclk);
        checkOutput("rst_div", 64'(div_out), 64'(packArr(m_ldiv)));
        checkOutput("rst_phase", 64'(phase_out), 64'(packArr(m_lphase)));
        checkOutput("rst_err", 64'(err), 64'(m_err));
        checkOutput("rst_ready", 64'(cfg_ready), 64'd1);
        repeat (8) @(negedge refclk);
        return;
      end
      if (probe && k == 3) begin
        commit = 1'b1; cfg_valid = 1'b1; cfg_addr = pa; cfg_data = pd;
        #1;
        checkOutput("drop_pulse", 64'(commit_drop), 64'd1);
      end
      if (probe && k == 4) begin
        commit = 1'b0;
        #1;
        checkOutput("drop_clear", 64'(commit_drop), 64'd0);
      end
    end
    if (probe) begin
      @(posedge refclk);
      modelWrite(pa, pd);
      @(negedge refclk);
      cfg_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] a;
    int nw;
    modelReset();
    repeat (3) begin
      @(negedge refclk);
      checkOutput("gen_reset_in_reset", 64'(gen_reset), 64'd1);
    end
    reset = 1'b0;
    @(negedge refclk);
    checkOutput("rst_div_out", 64'(div_out), 64'(packArr(m_ldiv)));
    checkOutput("rst_phase_out", 64'(phase_out), 64'(packArr(m_lphase)));
    checkOutput("rst_gen_reset", 64'(gen_reset), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_ready", 64'(cfg_ready), 64'd1);

    applyStimulus(4'h2, 8'd10);
    applyStimulus(4'hA, 8'd3);
    doCommit(0, 0, 4'h0, 8'h0, 0);
    applyStimulus(4'h0, 8'd0);
    doCommit(0, 0, 4'h0, 8'h0, 0);
    applyStimulus(4'b0110, 8'd55);
    errClear(0);
    applyStimulus(4'h5, 8'd250);
    applyStimulus(4'hD, 8'd10);
    doCommit(0, 0, 4'h0, 8'h0, 0);
    errClear(0);
    doCommit(1, 0, 4'h0, 8'h0, 0);
    doCommit(0, 1, 4'h1, 8'd7, 0);
    errClear(1);
    errClear(0);

    for (int it = 0; it < 30; it++) begin
      nw = $urandom_range(0, 3);
      for (int w = 0; w < nw; w++) begin
        a = 4'($urandom_range(0, 15));
        applyStimulus(a, 8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 4) == 0) errClear($urandom_range(0, 1) == 1);
      a = 4'($urandom_range(0, 15));
      doCommit($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, a,
               8'($urandom_range(0, 255)), 1'b0);
    end

    applyStimulus(4'h4, 8'd99);
    doCommit(0, 0, 4'h0, 8'h0, 1);
    applyStimulus(4'h3, 8'd17);
    doCommit(0, 0, 4'h0, 8'h0, 0);
    repeat (10) @(negedge refclk);
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
